hilo_muldiv: RTL and testbench
==============================

# hilo_muldiv

Multi-cycle multiply/divide unit that owns the HI and LO registers of the pipelined MIPS-Lite core. The EX stage launches MULT/MULTU/DIV/DIVU or writes MTHI/MTLO here. The block drives HiOut/LoOut into the writeback select mux that serves MFHI/MFLO. It is the writer side of the HI/LO interface whose reader is that mux.

## Interface
- WIDTH, 32, operand and HI/LO register width; the iteration count equals WIDTH.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request, sampled on the rising edge.
- op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 reserved, ignored.
- A  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- B  input  WIDTH  multiplier / divisor; ignored for MTHI/MTLO.
- busy  output  1  high while a mul/div is in progress (state ≠ IDLE).
- done  output  1  one-cycle registered pulse when HI/LO have just been written by a mul/div.
- HiOut  output  WIDTH  current HI register.
- LoOut  output  WIDTH  current LO register.

## Operation
- States: IDLE, RUN, FIN.
- Reset: state IDLE, HiOut = 0, LoOut = 0, busy = 0, done = 0, iteration counter = 0.
- IDLE + start + mul/div op:
  - Latch the operand magnitudes, signed-ness, result sign(s) and op.
  - Clear the accumulator; counter = 0; go to RUN.
- IDLE + start + MTHI/MTLO:
  - HiOut (resp. LoOut) = A on the same edge.
  - State stays IDLE; done stays 0.
- RUN: one iteration per cycle; counter increments; after WIDTH iterations go to FIN.
  - Multiply: shift-add, 2·WIDTH-bit product.
  - Divide: restoring shift-subtract; quotient in the low half, remainder in the high half.
- FIN: apply sign correction, write HiOut/LoOut, pulse done, return to IDLE.
- Result rules:
  - MULT/MULTU: {HiOut, LoOut} = full 2·WIDTH product. MULT is two's-complement signed; MULTU is unsigned.
  - DIV/DIVU: LoOut = quotient, HiOut = remainder.
  - Signed DIV truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero (DIV or DIVU): LoOut = all ones, HiOut = A. Same latency; no exception.
  - DIV 0x80000000 / 0xFFFFFFFF: LoOut = 0x80000000, HiOut = 0.
- start while busy: ignored entirely, including MTHI/MTLO. The hazard unit guarantees no issue while busy.
- Reserved op with start: no state change.

## Timing
- Mul/div start accepted at edge E0.
- busy = 1 from the cycle after E0 through the cycle that ends with edge E33.
- RUN spans 32 cycles (E1..E32); FIN is the cycle ending at E33.
- HiOut/LoOut take the new result at E33. done = 1 for exactly the cycle after E33; busy = 0 in that same cycle.
- Latency from start to valid HI/LO: WIDTH+2 edges.
- A new start may be accepted in the done cycle (back-to-back).
- MTHI/MTLO: value visible on HiOut/LoOut in the cycle after the start edge.
- HiOut/LoOut hold their old values for the whole of RUN/FIN; no partial results are visible.
- rst during RUN/FIN: the operation is abandoned, every output returns to its reset value next cycle, and done is never pulsed.
- start and rst in the same cycle: rst wins.

## Structure
- Shared package holds:
  - op encodings (OP_MULTU…OP_MTLO);
  - state enum (IDLE/RUN/FIN);
  - counter width derived from WIDTH.
- One sub-module, hilo_signfix: combinational absolute-value / conditional negate. It is used at operand latch and at FIN.
- The main module holds the FSM, counter, 2·WIDTH-bit accumulator, and the HI/LO registers.

## Test plan
- Reset, then MTHI 0x12345678, then MTLO 0x9ABCDEF0:
  - HiOut = 0x12345678 and LoOut = 0x9ABCDEF0 the following cycles;
  - busy and done stay 0.
- MULTU 0xFFFFFFFF × 2:
  - busy high 33 cycles, done pulse at E33+;
  - HiOut = 0x00000001, LoOut = 0xFFFFFFFE.
- MULT 0xFFFFFFFF × 2:
  - HiOut = 0xFFFFFFFF, LoOut = 0xFFFFFFFE.
- DIV -7 / 2: LoOut = 0xFFFFFFFD, HiOut = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: LoOut = 0x80000000, HiOut = 0.
- DIVU 5 / 0: LoOut = 0xFFFFFFFF, HiOut = 5.
- MULTU with start re-asserted (MTLO) mid-RUN, then rst asserted at cycle 10 of a second MULTU:
  - MTLO ignored; the first result is correct;
  - after rst, HiOut = LoOut = 0, busy = 0, and no done pulse.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// rtl/hilo_muldiv_pkg.sv - Shared op encodings, FSM states and counter sizing for the HI/LO mul/div unit.
package hilo_muldiv_pkg;

    localparam int HL_WIDTH = 32;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } hl_state_e;

    // Wide enough to hold the iteration count WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/hilo_signfix.sv
// rtl/hilo_signfix.sv - Combinational conditional two's-complement negate (absolute value / sign restore).
module hilo_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - Multi-cycle shift-add multiply / restoring divide unit owning the HI and LO registers.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = HL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    localparam int CW = cnt_width(WIDTH);

    hl_state_e          r_state;
    hl_state_e          w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_divz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_signed = op[0];
    assign w_neg_a  = w_signed & A[WIDTH-1];
    assign w_neg_b  = w_signed & B[WIDTH-1];

    hilo_signfix #(.W(WIDTH)) u_abs_a (.i_val(A), .i_neg(w_neg_a), .o_val(w_abs_a));
    hilo_signfix #(.W(WIDTH)) u_abs_b (.i_val(B), .i_neg(w_neg_b), .o_val(w_abs_b));

    hilo_signfix #(.W(2*WIDTH)) u_fix_prod (.i_val(r_acc), .i_neg(r_neg_q), .o_val(w_prod_fix));
    hilo_signfix #(.W(WIDTH)) u_fix_quot (.i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_q), .o_val(w_quot_fix));
    hilo_signfix #(.W(WIDTH)) u_fix_rem (.i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_r), .o_val(w_rem_fix));

    // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});

    // Divide: partial remainder lives in the high half, quotient bits shift into the low half.
    assign w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_opb};
    assign w_ge     = (w_rem_sh >= {1'b0, r_opb});

    always_comb begin
        w_acc_step = r_acc;
        if (r_is_div) begin
            if (w_ge) begin
                w_acc_step = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_step = {w_sum, r_acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start && is_muldiv(op)) w_state_next = RUN;
            RUN:  if (r_cnt == CW'(WIDTH - 1)) w_state_next = FIN;
            FIN:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_divz   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == FIN);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (is_muldiv(op)) begin
                            r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
                            r_opb    <= w_abs_b;
                            r_is_div <= op[1];
                            r_neg_q  <= w_neg_a ^ w_neg_b;
                            r_neg_r  <= w_neg_a;
                            r_divz   <= (B == '0);
                            r_cnt    <= '0;
                        end else if (op == OP_MTHI) begin
                            r_hi <= A;
                        end else if (op == OP_MTLO) begin
                            r_lo <= A;
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + CW'(1);
                end
                FIN: begin
                    if (r_is_div) begin
                        // A zero divisor leaves the dividend in the remainder, so HI already equals A.
                        r_hi <= w_rem_fix;
                        r_lo <= r_divz ? {WIDTH{1'b1}} : w_quot_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != IDLE);
    assign done  = r_done;
    assign HiOut = r_hi;
    assign LoOut = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - Directed self-checking bench for hilo_muldiv.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HiOut;
    logic [31:0] LoOut;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .HiOut(HiOut), .LoOut(LoOut)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one start pulse; returns at the negedge of the cycle after the start edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = 3'b110; A = '0; B = '0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit inject);
        logic [31:0] old_hi, old_lo;
        int  n;
        bit  early_done, changed;
        old_hi = HiOut; old_lo = LoOut;
        issue(o, a, b);
        n = 0; early_done = 0; changed = 0;
        while (busy === 1'b1 && n < 100) begin
            if (done !== 1'b0) early_done = 1;
            if (HiOut !== old_hi || LoOut !== old_lo) changed = 1;
            if (inject && n == 5) begin
                start = 1'b1; op = 3'b101; A = 32'hDEADBEEF;
            end else begin
                start = 1'b0; op = 3'b110; A = '0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, " busy_cycles"}, n, 33);
        chk({tag, " no_early_done"}, {31'b0, early_done}, 32'd0);
        chk({tag, " hilo_held"}, {31'b0, changed}, 32'd0);
        chk({tag, " done"}, {31'b0, done}, 32'd1);
        chk({tag, " hi"}, HiOut, exp_hi);
        chk({tag, " lo"}, LoOut, exp_lo);
        @(negedge clk);
        chk({tag, " done_cleared"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int  n;
        bit  saw;
        rst = 1'b1; start = 1'b0; op = 3'b110; A = '0; B = '0;
        repeat (2) @(negedge clk);
        chk("reset hi", HiOut, 32'd0);
        chk("reset lo", LoOut, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        rst = 1'b0;

        issue(3'b100, 32'h12345678, 32'hFFFFFFFF);
        chk("mthi hi", HiOut, 32'h12345678);
        chk("mthi busy", {31'b0, busy}, 32'd0);
        issue(3'b101, 32'h9ABCDEF0, 32'd0);
        chk("mtlo lo", LoOut, 32'h9ABCDEF0);
        chk("mtlo hi", HiOut, 32'h12345678);
        chk("mtlo busy_done", {30'b0, busy, done}, 32'd0);

        issue(3'b110, 32'h11111111, 32'd3);
        chk("reserved hi", HiOut, 32'h12345678);
        chk("reserved lo", LoOut, 32'h9ABCDEF0);
        chk("reserved busy", {31'b0, busy}, 32'd0);

        run_op("multu", 3'b000, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 0);
        run_op("mult", 3'b001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op("mult_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
        run_op("div_neg", 3'b011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
        run_op("divu_zero", 3'b010, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, 0);
        run_op("div_zero", 3'b011, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);
        run_op("divu_big", 3'b010, 32'hFFFFFFFF, 32'd10, 32'h00000005, 32'h19999999, 0);
        run_op("multu_inject", 3'b000, 32'h00001234, 32'h00000010, 32'h00000000, 32'h00012340, 1);

        issue(3'b000, 32'd3, 32'd5);
        n = 1;
        while (n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("abort busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort hi", HiOut, 32'd0);
        chk("abort lo", LoOut, 32'd0);
        chk("abort busy", {31'b0, busy}, 32'd0);
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) saw = 1;
            @(negedge clk);
        end
        chk("abort no_done", {31'b0, saw}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
